// File: rtl/cpu_read_sequencer_pkg.sv
// cpu_rdseq_pkg: state encoding, floating-bus default and one-hot helpers shared by the read sequencer.
package cpu_rdseq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3} state_t;
  localparam int MAX_SRC = 32;
  localparam logic [7:0] RDSEQ_DEFAULT_DATA = 8'hFF;
  function automatic logic [MAX_SRC-1:0] lowest_one_hot(input logic [MAX_SRC-1:0] v);
    return v & (~v + MAX_SRC'(1));
  endfunction
  function automatic logic [4:0] one_hot_index(input logic [MAX_SRC-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < MAX_SRC; i++) if (v[i]) r = 5'(i);
    return r;
  endfunction
endpackage

// File: rtl/cpu_read_sequencer_if.sv
// cpu_read_sequencer_if: Z80 read strobe, source selects/data and sequencer results.
// CPU_RDSEQ_CONFLICT_EN adds the sticky cs_conflict flag.
interface cpu_read_sequencer_if #(parameter int NSRC = 8);
  logic              z80_rd_n;
  logic [NSRC-1:0]   src_cs;
  logic [NSRC*8-1:0] src_data;
  logic [7:0]        out_data;
  logic              cpu_wait_n;
  logic [NSRC-1:0]   grant;
  logic              rd_active;
  logic              data_valid;
`ifdef CPU_RDSEQ_CONFLICT_EN
  logic              cs_conflict;
  modport master (output z80_rd_n, src_cs, src_data,
                  input out_data, cpu_wait_n, grant, rd_active, data_valid, cs_conflict);
  modport slave  (input z80_rd_n, src_cs, src_data,
                  output out_data, cpu_wait_n, grant, rd_active, data_valid, cs_conflict);
`else
  modport master (output z80_rd_n, src_cs, src_data,
                  input out_data, cpu_wait_n, grant, rd_active, data_valid);
  modport slave  (input z80_rd_n, src_cs, src_data,
                  output out_data, cpu_wait_n, grant, rd_active, data_valid);
`endif
endinterface

// File: rtl/cpu_read_sequencer_sync.sv
// rdseq_sync: two-flop synchroniser for the Z80 read strobe plus a delay flop for falling-edge detect.
module rdseq_sync (
  input  logic pll0_250MHz,
  input  logic reset,
  input  logic z80_rd_n,
  output logic rd_s,
  output logic start
);
  logic meta, rd_q;
  always_ff @(posedge pll0_250MHz or posedge reset)
    if (reset) {meta, rd_s, rd_q} <= 3'b111;
    else       {meta, rd_s, rd_q} <= {z80_rd_n, meta, rd_s};
  assign start = ~rd_s & rd_q;
endmodule

// File: rtl/cpu_read_sequencer.sv
// cpu_read_sequencer: grants one read source per Z80 cycle, inserts per-source WAIT states, holds data.
// Optional CPU_RDSEQ_CONFLICT_EN adds a sticky multiple-chip-select flag.
module cpu_read_sequencer
  import cpu_rdseq_pkg::*;
#(
  parameter int                     NSRC         = 8,
  parameter int                     WAITW        = 4,
  parameter logic [NSRC*WAITW-1:0]  WAIT_TABLE   = '0,
  parameter logic [7:0]             DEFAULT_DATA = RDSEQ_DEFAULT_DATA
) (
  input logic                  pll0_250MHz,
  input logic                  reset,
  cpu_read_sequencer_if.slave  bus
);
  state_t            state, state_nx;
  logic [WAITW-1:0]  cnt, cnt_nx, n_wait;
  logic [7:0]        data_nx, sel_data;
  logic              wait_nx, valid_nx, active_nx, rd_s, start;
  logic [NSRC-1:0]   grant_nx, first, sel;
  logic [4:0]        idx;
  rdseq_sync u_sync (.pll0_250MHz(pll0_250MHz), .reset(reset), .z80_rd_n(bus.z80_rd_n),
                     .rd_s(rd_s), .start(start));
  // In IDLE the source is being chosen now; afterwards the latched grant selects it.
  assign first    = NSRC'(lowest_one_hot(MAX_SRC'(bus.src_cs)));
  assign sel      = (state == IDLE) ? first : bus.grant;
  assign idx      = one_hot_index(MAX_SRC'(sel));
  assign n_wait   = |sel ? WAIT_TABLE[idx*WAITW +: WAITW] : '0;
  assign sel_data = |sel ? bus.src_data[idx*8 +: 8] : DEFAULT_DATA;
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    data_nx   = bus.out_data;
    wait_nx   = bus.cpu_wait_n;
    valid_nx  = bus.data_valid;
    active_nx = bus.rd_active;
    grant_nx  = bus.grant;
    unique case (state)
      IDLE: if (start) begin
        active_nx = 1'b1;
        grant_nx  = first;
        cnt_nx    = n_wait;
        if (n_wait != '0) begin
          wait_nx  = 1'b0;
          state_nx = WAIT;
        end else begin
          data_nx  = sel_data;
          valid_nx = 1'b1;
          state_nx = CAPTURE;
        end
      end
      WAIT: if (rd_s) begin
        state_nx  = IDLE;
        wait_nx   = 1'b1;
        active_nx = 1'b0;
        grant_nx  = '0;
        cnt_nx    = '0;
      end else if (cnt == WAITW'(1)) begin
        data_nx  = sel_data;
        wait_nx  = 1'b1;
        valid_nx = 1'b1;
        cnt_nx   = '0;
        state_nx = CAPTURE;
      end else cnt_nx = cnt - WAITW'(1);
      CAPTURE: state_nx = HOLD;
      HOLD: if (rd_s) begin
        state_nx  = IDLE;
        valid_nx  = 1'b0;
        active_nx = 1'b0;
        grant_nx  = '0;
      end
    endcase
  end
  always_ff @(posedge pll0_250MHz or posedge reset)
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.out_data   <= 8'h00;
      bus.cpu_wait_n <= 1'b1;
      bus.grant      <= '0;
      bus.rd_active  <= 1'b0;
      bus.data_valid <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      bus.out_data   <= data_nx;
      bus.cpu_wait_n <= wait_nx;
      bus.grant      <= grant_nx;
      bus.rd_active  <= active_nx;
      bus.data_valid <= valid_nx;
    end
`ifdef CPU_RDSEQ_CONFLICT_EN
  logic multi;
  assign multi = |(bus.src_cs & (bus.src_cs - NSRC'(1)));
  always_ff @(posedge pll0_250MHz or posedge reset)
    if (reset) bus.cs_conflict <= 1'b0;
    else       bus.cs_conflict <= bus.cs_conflict | (state == IDLE && start && multi);
`endif
endmodule

// File: doc/cpu_read_sequencer.md
Name: cpu_read_sequencer

Overview:
- Sequences every Z80 read cycle (memory or I/O) onto the CPU DATA INPUT bus.
- Synchronises the CPU read strobe into the pll0_250MHz domain and grants exactly one source per cycle, using fixed priority over the source chip-selects.
- Inserts a per-source programmable number of WAIT states, then captures the granted source's data and holds it stable until the CPU ends the cycle.
- Sits between the address/IO decoders (chip-select producers) and the Z80 data-in / WAIT pins.

Parameters:
- NSRC, 8: number of read sources; index 0 has the highest priority.
- WAITW, 4: width of each wait-state count.
- WAIT_TABLE, {NSRC{4'd0}}: packed NSRC×WAITW wait counts; source i uses bits [i*WAITW +: WAITW].
- DEFAULT_DATA, 8'hFF: data returned when no chip-select is asserted (floating-bus value).

Ports:
- pll0_250MHz, input, 1: sole clock.
- reset, input, 1: asynchronous, active-high reset.
- z80_rd_n, input, 1: CPU read strobe, asynchronous to the clock, active low.
- src_cs, input, NSRC: one-hot chip-selects from the decoders, valid while z80_rd_n is low.
- src_data, input, NSRC*8: flattened source data; source i occupies [i*8 +: 8].
- out_data, output, 8: registered data to the Z80 data-in bus.
- cpu_wait_n, output, 1: registered Z80 WAIT, active low.
- grant, output, NSRC: registered one-hot grant for the current cycle; all zeros when no source is selected.
- rd_active, output, 1: high from edge detection until the cycle is released.
- data_valid, output, 1: high while out_data holds captured data for the current cycle.

Behaviour:
- Reset values: out_data=8'h00, cpu_wait_n=1, grant=0, rd_active=0, data_valid=0, state=IDLE, counter=0, sync flops=1.
- Read strobe synchronisation:
  - z80_rd_n passes through a 2-flop synchroniser into rd_s; a third flop holds rd_q.
  - A read start is the cycle where rd_s=0 and rd_q=1.
- States: IDLE, WAIT, CAPTURE, HOLD.
- IDLE:
  - On read start, latch grant = lowest-index asserted bit of src_cs and set rd_active=1.
  - Load counter = WAIT_TABLE[grant].
  - If the count is greater than 0: cpu_wait_n<=0 and go to WAIT. Otherwise go to CAPTURE directly.
  - If src_cs is all zeros: grant=0, the wait count is 0, and the cycle goes to CAPTURE.
- WAIT:
  - The counter decrements each cycle. When the counter equals 1, go to CAPTURE, so WAIT lasts exactly N cycles.
  - If rd_s goes high (abort), go to IDLE: cpu_wait_n<=1, rd_active<=0, grant<=0, out_data unchanged, data_valid stays 0.
- CAPTURE (1 cycle):
  - out_data <= src_data[grant], or DEFAULT_DATA if grant=0.
  - cpu_wait_n<=1, data_valid<=1, then go to HOLD.
- HOLD:
  - out_data is frozen even if src_cs or src_data change.
  - When rd_s=1: data_valid<=0, rd_active<=0, grant<=0, go to IDLE. out_data retains its last value.
- Latency from read start:
  - out_data is valid 1 clock after read start when N=0.
  - out_data is valid N+1 clocks after read start when N>0.
  - cpu_wait_n is low for exactly N clocks.
- A new read start is recognised only in IDLE. A read start coinciding with release is impossible because a single synchronised strobe cannot go both ways in one cycle.
- Changes on src_cs after grant is latched are ignored for the rest of the cycle.
- Asserting reset at any point returns every output to its reset value immediately; no partial cycle resumes after reset.

Optional Feature:
- Macro: CPU_RDSEQ_CONFLICT_EN.
- When defined:
  - Adds output cs_conflict (1 bit, reset 0).
  - Sets sticky when more than one src_cs bit is asserted at a read start; cleared only by reset.
  - Grant is still chosen by priority.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_rdseq_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, CAPTURE=2'd2, HOLD=2'd3),
  - the DEFAULT_DATA constant,
  - a function returning the lowest set bit as one-hot, and a matching one-hot-to-index function.
- One natural sub-module: rdseq_sync, the 2-flop synchroniser plus edge-detect flop (asynchronous reset to 1).

Test Plan:
- WAIT_TABLE source 2 = 3, src_cs=8'b0000_0100, src_data[2]=8'hA5, z80_rd_n falls → cpu_wait_n low for exactly 3 clocks; out_data=8'hA5 with data_valid=1 on the 4th clock after read start; holds until rd_n rises.
- Source 0 with 0 waits, data 8'h3C → cpu_wait_n never drops; out_data=8'h3C 1 clock after read start; grant=8'h01.
- src_cs=8'b0001_0010 with data1=8'h11, data4=8'h44 → grant=8'h02, out_data=8'h11; with CPU_RDSEQ_CONFLICT_EN defined, cs_conflict=1 and stays set after the cycle.
- src_cs=0 → out_data=8'hFF, grant=0, no WAIT asserted.
- Source with 5 waits, z80_rd_n released after 2 wait clocks → state returns to IDLE, cpu_wait_n=1, out_data keeps its prior value, data_valid never rises.
- Assert reset during WAIT with 4 waits pending → next edge shows cpu_wait_n=1, out_data=8'h00, grant=0; the next read sequences normally.
